stream_matrix_mem_unblock: RTL and testbench

- Reassembly buffer on the output side of the blocked matrix-vector datapath.
- Accepts a result matrix streamed in blocked (column-block-major) order, scatters it into a single-port-per-side BRAM at row-major addresses, then streams it out in linear row-major order.
- Inverse of the blocked vector replay in front of the MAC array.
- Single bank: one full write phase, then one full read phase, strictly alternating.

---
 rtl/stream_mem_pkg.sv | 7 +
 rtl/mem_top.sv | 27 ++
 rtl/stream_matrix_mem_unblock.sv | 177 +++++++++++++++++
 tb/tb_stream_matrix_mem_unblock.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mem_pkg.sv
// State types shared by the blocked vector memory and the matrix unblocking buffer.
package stream_mem_pkg;

   typedef enum logic [1:0] {WRRESET, WRIDLE, WRDATA} wstate_t;
   typedef enum logic [1:0] {RDRESET, RDIDLE, RDPRIME, RDDATA} rstate_t;

endpackage

// File: rtl/mem_top.sv
// Simple dual-port BRAM: port A writes, port B reads with one cycle latency, read-first.
module mem_top #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DEPTH  = 4096
) (
   input  logic              clk,
   input  logic              wea,
   input  logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] dina,
   input  logic [ADDR_W-1:0] addrb,
   output logic [DATA_W-1:0] doutb
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] doutb_q;

   always_ff @(posedge clk) begin
      if (wea) begin
         mem[addra] <= dina;
      end
      doutb_q <= mem[addrb];
   end

   assign doutb = doutb_q;

endmodule

// File: rtl/stream_matrix_mem_unblock.sv
// Reassembles a column-block-major result matrix into row-major order through one BRAM bank:
// a full scatter-write phase followed by a full linear read phase.
module stream_matrix_mem_unblock
   import stream_mem_pkg::*;
#(
   parameter int unsigned D_W          = 8,
   parameter int unsigned MATRIXSIZE_W = 24,
   parameter int unsigned MEM_DEPTH    = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [D_W-1:0]          in_mat_tdata,
   input  logic                    in_mat_tvalid,
   output logic                    in_mat_tready,
   input  logic                    in_mat_tlast,
   output logic [D_W-1:0]          out_mat_tdata,
   output logic                    out_mat_tvalid,
   input  logic                    out_mat_tready,
   output logic                    out_mat_tlast,
   input  logic [MATRIXSIZE_W-1:0] DIM1,
   input  logic [MATRIXSIZE_W-1:0] DIM2,
   input  logic [MATRIXSIZE_W-1:0] BLOCKS,
   input  logic [MATRIXSIZE_W-1:0] BLOCK_WIDTH,
   output logic                    len_err
);

   localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);

   wstate_t wstate_q, wstate_d;
   rstate_t rstate_q, rstate_d;

   logic [MATRIXSIZE_W-1:0] col_idx_q, col_idx_d;
   logic [MATRIXSIZE_W-1:0] row_idx_q, row_idx_d;
   logic [MATRIXSIZE_W-1:0] block_cntr_q, block_cntr_d;
   logic [ADDR_W-1:0]       row_base_q, row_base_d;
   logic [ADDR_W-1:0]       block_offset_q, block_offset_d;
   logic [ADDR_W-1:0]       rdaddr_q, rdaddr_d;
   logic                    len_err_q, len_err_d;
   logic                    tlast_q, tlast_d;

   logic                    write_hs, write_last, exp_last;
   logic                    col_end, row_end, blk_end;
   logic                    read_hs, read_last;
   logic [MATRIXSIZE_W-1:0] mat_elems;
   logic [ADDR_W-1:0]       last_addr;
   logic [ADDR_W-1:0]       wr_addr;
   logic [ADDR_W-1:0]       rd_addr_b;

   assign in_mat_tready  = (wstate_q == WRDATA);
   assign out_mat_tvalid = (rstate_q == RDDATA);
   assign out_mat_tlast  = tlast_q;
   assign len_err        = len_err_q;

   assign write_hs   = in_mat_tvalid & in_mat_tready;
   assign write_last = write_hs & in_mat_tlast;
   assign read_hs    = out_mat_tvalid & out_mat_tready;
   assign read_last  = read_hs & tlast_q;

   assign col_end  = (col_idx_q == BLOCK_WIDTH - MATRIXSIZE_W'(1));
   assign row_end  = (row_idx_q == DIM1 - MATRIXSIZE_W'(1));
   assign blk_end  = (block_cntr_q == BLOCKS - MATRIXSIZE_W'(1));
   assign exp_last = col_end & row_end & blk_end;

   assign mat_elems = MATRIXSIZE_W'(DIM1 * DIM2);
   assign last_addr = ADDR_W'(mat_elems - MATRIXSIZE_W'(1));
   assign wr_addr   = row_base_q + block_offset_q + ADDR_W'(col_idx_q);
   // Look one address ahead on a handshake so the BRAM latency never shows as a bubble.
   assign rd_addr_b = read_hs ? rdaddr_q + ADDR_W'(1) : rdaddr_q;

   // Write side: FSM, scatter address counters and length check.
   always_comb begin
      wstate_d       = wstate_q;
      col_idx_d      = col_idx_q;
      row_idx_d      = row_idx_q;
      block_cntr_d   = block_cntr_q;
      row_base_d     = row_base_q;
      block_offset_d = block_offset_q;
      len_err_d      = len_err_q;

      case (wstate_q)
         WRRESET: wstate_d = WRIDLE;
         WRIDLE:  if (rstate_q == RDIDLE) wstate_d = WRDATA;
         WRDATA:  if (write_last) wstate_d = WRIDLE;
         default: wstate_d = WRRESET;
      endcase

      if (write_hs) begin
         if (in_mat_tlast != exp_last) len_err_d = 1'b1;
         if (write_last) begin
            col_idx_d      = '0;
            row_idx_d      = '0;
            block_cntr_d   = '0;
            row_base_d     = '0;
            block_offset_d = '0;
         end else begin
            col_idx_d = col_idx_q + MATRIXSIZE_W'(1);
            if (col_end) begin
               col_idx_d  = '0;
               row_idx_d  = row_idx_q + MATRIXSIZE_W'(1);
               row_base_d = row_base_q + ADDR_W'(DIM2);
               if (row_end) begin
                  row_idx_d      = '0;
                  row_base_d     = '0;
                  block_offset_d = block_offset_q + ADDR_W'(BLOCK_WIDTH);
                  block_cntr_d   = block_cntr_q + MATRIXSIZE_W'(1);
                  if (blk_end) begin
                     block_cntr_d   = '0;
                     block_offset_d = '0;
                  end
               end
            end
         end
      end
   end

   // Read side: FSM, linear address and registered tlast.
   always_comb begin
      rstate_d = rstate_q;
      rdaddr_d = rdaddr_q;

      case (rstate_q)
         RDRESET: rstate_d = RDIDLE;
         RDIDLE:  if (write_last) rstate_d = RDPRIME;
         RDPRIME: rstate_d = RDDATA;
         RDDATA:  if (read_last) rstate_d = RDIDLE;
         default: rstate_d = RDRESET;
      endcase

      if (rstate_q != RDDATA || read_last) begin
         rdaddr_d = '0;
      end else if (read_hs) begin
         rdaddr_d = rdaddr_q + ADDR_W'(1);
      end

      tlast_d = (rstate_d == RDDATA) && (rdaddr_d == last_addr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wstate_q       <= WRRESET;
         rstate_q       <= RDRESET;
         col_idx_q      <= '0;
         row_idx_q      <= '0;
         block_cntr_q   <= '0;
         row_base_q     <= '0;
         block_offset_q <= '0;
         rdaddr_q       <= '0;
         len_err_q      <= 1'b0;
         tlast_q        <= 1'b0;
      end else begin
         wstate_q       <= wstate_d;
         rstate_q       <= rstate_d;
         col_idx_q      <= col_idx_d;
         row_idx_q      <= row_idx_d;
         block_cntr_q   <= block_cntr_d;
         row_base_q     <= row_base_d;
         block_offset_q <= block_offset_d;
         rdaddr_q       <= rdaddr_d;
         len_err_q      <= len_err_d;
         tlast_q        <= tlast_d;
      end
   end

   mem_top #(
      .DATA_W (D_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (MEM_DEPTH)
   ) u_mem (
      .clk   (clk),
      .wea   (write_hs),
      .addra (wr_addr),
      .dina  (in_mat_tdata),
      .addrb (rd_addr_b),
      .doutb (out_mat_tdata)
   );

endmodule

// File: tb/tb_stream_matrix_mem_unblock.sv
// Bench for the matrix unblocking buffer: scatters blocked input through a row-major memory model
// and checks the streamed output order, tlast, len_err, latency, stalls and reset.
module tb_stream_matrix_mem_unblock;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_mat_tdata;
   logic        in_mat_tvalid;
   logic        in_mat_tready;
   logic        in_mat_tlast;
   logic [7:0]  out_mat_tdata;
   logic        out_mat_tvalid;
   logic        out_mat_tready;
   logic        out_mat_tlast;
   logic [23:0] DIM1, DIM2, BLOCKS, BLOCK_WIDTH;
   logic        len_err;

   int n_tests = 0;
   int n_fail  = 0;

   int cfg_d1, cfg_d2, cfg_bw, cfg_blk;
   logic [7:0] mdl_mem   [4096];
   bit         mdl_known [4096];

   always #5 clk = ~clk;

   stream_matrix_mem_unblock dut (
      .clk            (clk),
      .rst            (rst),
      .in_mat_tdata   (in_mat_tdata),
      .in_mat_tvalid  (in_mat_tvalid),
      .in_mat_tready  (in_mat_tready),
      .in_mat_tlast   (in_mat_tlast),
      .out_mat_tdata  (out_mat_tdata),
      .out_mat_tvalid (out_mat_tvalid),
      .out_mat_tready (out_mat_tready),
      .out_mat_tlast  (out_mat_tlast),
      .DIM1           (DIM1),
      .DIM2           (DIM2),
      .BLOCKS         (BLOCKS),
      .BLOCK_WIDTH    (BLOCK_WIDTH),
      .len_err        (len_err)
   );

   task automatic apply_cfg(input int d1, input int bw, input int blk);
      cfg_d1 = d1; cfg_bw = bw; cfg_blk = blk; cfg_d2 = bw * blk;
      DIM1 = 24'(d1); DIM2 = 24'(cfg_d2); BLOCKS = 24'(blk); BLOCK_WIDTH = 24'(bw);
   endtask

   // k-th element of the blocked stream lands at row-major position (r, b*bw + c).
   task automatic model_write(input int k, input logic [7:0] d);
      int per_blk, b, rem, r, c, a;
      per_blk = cfg_d1 * cfg_bw;
      b   = k / per_blk;
      rem = k % per_blk;
      r   = rem / cfg_bw;
      c   = rem % cfg_bw;
      a   = r * cfg_d2 + b * cfg_bw + c;
      mdl_mem[a]   = d;
      mdl_known[a] = 1'b1;
   endtask

   task automatic drive_in(input logic [7:0] data [$], input int last_idx, input int valid_pct);
      int idx, cyc;
      idx = 0; cyc = 0;
      while (idx <= last_idx && cyc < 4000) begin
         @(negedge clk); cyc++;
         in_mat_tvalid = ($urandom_range(0, 99) < valid_pct);
         in_mat_tdata  = data[idx];
         in_mat_tlast  = (idx == last_idx);
         if (in_mat_tvalid && in_mat_tready === 1'b1) begin
            model_write(idx, data[idx]);
            idx++;
         end
      end
      @(negedge clk);
      in_mat_tvalid = 1'b0;
      in_mat_tlast  = 1'b0;
      n_tests++;
      if (idx <= last_idx) begin
         n_fail++;
         $display("FAIL drive_timeout: accepted %0d required %0d", idx, last_idx + 1);
      end
   endtask

   task automatic collect(input int n_take, input int n_total, input int ready_pct, input bit chk_wr_blocked);
      logic [7:0] exp_q [$];
      bit         kn_q  [$];
      logic [7:0] held;
      bit         stall;
      int         k, cyc;
      for (int a = 0; a < n_take; a++) begin
         exp_q.push_back(mdl_mem[a]);
         kn_q.push_back(mdl_known[a]);
      end
      k = 0; cyc = 0; stall = 1'b0; held = '0;
      while (k < n_take && cyc < 4000) begin
         @(negedge clk); cyc++;
         if (stall && out_mat_tvalid === 1'b1) begin
            n_tests++;
            if (out_mat_tdata !== held) begin
               n_fail++;
               $display("FAIL stall_hold: got %0h required %0h", out_mat_tdata, held);
            end
         end
         if (chk_wr_blocked) begin
            n_tests++;
            if (in_mat_tready !== 1'b0) begin
               n_fail++;
               $display("FAIL writer_blocked: in tready %0b required 0", in_mat_tready);
            end
         end
         out_mat_tready = ($urandom_range(0, 99) < ready_pct);
         if (out_mat_tvalid === 1'b1 && out_mat_tready) begin
            if (kn_q[k]) begin
               n_tests++;
               if (out_mat_tdata !== exp_q[k]) begin
                  n_fail++;
                  $display("FAIL out_data[%0d]: got %0h required %0h", k, out_mat_tdata, exp_q[k]);
               end
            end
            n_tests++;
            if (out_mat_tlast !== (k == n_total - 1)) begin
               n_fail++;
               $display("FAIL out_tlast[%0d]: got %0b required %0b", k, out_mat_tlast, (k == n_total - 1));
            end
            k++;
            stall = 1'b0;
         end else begin
            stall = (out_mat_tvalid === 1'b1);
            held  = out_mat_tdata;
         end
      end
      @(negedge clk);
      out_mat_tready = 1'b0;
      n_tests++;
      if (k < n_take) begin
         n_fail++;
         $display("FAIL collect_timeout: got %0d outputs required %0d", k, n_take);
      end
      if (n_take == n_total) begin
         n_tests++;
         if (out_mat_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL tvalid_after_last: got %0b required 0", out_mat_tvalid);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_mat_tvalid = 1'b0; in_mat_tlast = 1'b0; in_mat_tdata = '0; out_mat_tready = 1'b0;
      apply_cfg(2, 2, 2);
      repeat (3) @(negedge clk);
      n_tests += 4;
      if (in_mat_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %0b required 0", in_mat_tready); end
      if (out_mat_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %0b required 0", out_mat_tvalid); end
      if (out_mat_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %0b required 0", out_mat_tlast); end
      if (len_err !== 1'b0) begin n_fail++; $display("FAIL reset_len_err: got %0b required 0", len_err); end
      rst = 1'b0;
   endtask

   task automatic test_basic_reorder();
      logic [7:0] q [$];
      logic [7:0] want [$];
      apply_cfg(2, 2, 2);
      q = '{8'd0, 8'd1, 8'd10, 8'd11, 8'd2, 8'd3, 8'd12, 8'd13};
      want = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd10, 8'd11, 8'd12, 8'd13};
      drive_in(q, 7, 100);
      for (int a = 0; a < 8; a++) begin
         n_tests++;
         if (mdl_mem[a] !== want[a]) begin
            n_fail++;
            $display("FAIL model_order[%0d]: got %0h required %0h", a, mdl_mem[a], want[a]);
         end
      end
      collect(8, 8, 100, 1'b0);
      n_tests++;
      if (len_err !== 1'b0) begin n_fail++; $display("FAIL basic_len_err: got %0b required 0", len_err); end
   endtask

   task automatic test_single_element();
      int cyc;
      apply_cfg(1, 1, 1);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (in_mat_tready !== 1'b1 && cyc < 50);
      in_mat_tvalid = 1'b1; in_mat_tdata = 8'h5A; in_mat_tlast = 1'b1;
      model_write(0, 8'h5A);
      @(negedge clk);
      in_mat_tvalid = 1'b0; in_mat_tlast = 1'b0;
      n_tests++;
      if (out_mat_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %0b required 0", out_mat_tvalid); end
      @(negedge clk);
      n_tests += 3;
      if (out_mat_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_latency: tvalid %0b required 1", out_mat_tvalid); end
      if (out_mat_tdata !== 8'h5A) begin n_fail++; $display("FAIL single_data: got %0h required 5a", out_mat_tdata); end
      if (out_mat_tlast !== 1'b1) begin n_fail++; $display("FAIL single_tlast: got %0b required 1", out_mat_tlast); end
      out_mat_tready = 1'b1;
      @(negedge clk);
      out_mat_tready = 1'b0;
      n_tests++;
      if (out_mat_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_done: tvalid %0b required 0", out_mat_tvalid); end
   endtask

   task automatic test_backpressure();
      logic [7:0] q [$];
      apply_cfg(2, 2, 2);
      for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
      drive_in(q, 7, 50);
      collect(8, 8, 50, 1'b0);
   endtask

   task automatic test_early_tlast();
      logic [7:0] q [$];
      apply_cfg(2, 2, 2);
      q = '{8'd0, 8'd1, 8'd10, 8'd11, 8'd2};
      drive_in(q, 4, 100);
      n_tests++;
      if (len_err !== 1'b1) begin n_fail++; $display("FAIL early_len_err: got %0b required 1", len_err); end
      collect(8, 8, 70, 1'b1);
      repeat (4) @(negedge clk);
      n_tests++;
      if (len_err !== 1'b1) begin n_fail++; $display("FAIL len_err_sticky: got %0b required 1", len_err); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] qa [$];
      logic [7:0] qb [$];
      apply_cfg(2, 2, 2);
      for (int i = 0; i < 8; i++) begin
         qa.push_back(8'($urandom));
         qb.push_back(8'(100 + i));
      end
      drive_in(qa, 7, 100);
      fork
         drive_in(qb, 7, 100);
         collect(8, 8, 100, 1'b1);
      join
      collect(8, 8, 100, 1'b0);
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] q [$];
      logic [7:0] q2 [$];
      apply_cfg(2, 2, 2);
      for (int i = 0; i < 8; i++) begin
         q.push_back(8'($urandom));
         q2.push_back(8'($urandom));
      end
      drive_in(q, 7, 100);
      collect(3, 8, 100, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      n_tests += 3;
      if (out_mat_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_tvalid: got %0b required 0", out_mat_tvalid); end
      if (in_mat_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_tready: got %0b required 0", in_mat_tready); end
      if (len_err !== 1'b0) begin n_fail++; $display("FAIL midrst_len_err: got %0b required 0", len_err); end
      rst = 1'b0;
      drive_in(q2, 7, 80);
      collect(8, 8, 80, 1'b0);
   endtask

   task automatic test_random_cfg();
      for (int it = 0; it < 6; it++) begin
         logic [7:0] q [$];
         int n;
         apply_cfg(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
         n = cfg_d1 * cfg_d2;
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         drive_in(q, n - 1, 70);
         collect(n, n, 60, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_basic_reorder();
      test_single_element();
      test_backpressure();
      test_back_to_back();
      test_random_cfg();
      test_early_tlast();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
